riscv_mem_seq: RTL and testbench

//  Shares one byte-wide synchronous RAM port between the instruction-fetch requester (I) and the load/store requester (D).

---
 rtl/riscv_mem_seq.sv | 258 +++++++++++++++++++++++++
 tb/tb_riscv_mem_seq.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mem_seq.sv
// riscv_mem_seq: shares one byte-wide synchronous RAM port between the
// instruction-fetch requester (I) and the load/store requester (D).
// Each granted access is split into 1, 2 or 4 byte beats. Read bytes are
// assembled little-endian into a word response.
module riscv_mem_seq #(
  parameter int XLEN       = 32,
  parameter int MEM_ADDR_W = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [XLEN-1:0]       i_req_addr,
  output logic                  i_rsp_valid,
  output logic [XLEN-1:0]       i_rsp_data,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic [XLEN-1:0]       d_req_addr,
  input  logic                  d_req_we,
  input  logic [1:0]            d_req_size,
  input  logic [XLEN-1:0]       d_req_wdata,
  output logic                  d_rsp_valid,
  output logic [XLEN-1:0]       d_rsp_data,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_re,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  busy
);

  // Access size encodings (RISC-V funct3 style); anything else means a word.
  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_X = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BEAT  = 2'd1,
    S_DRAIN = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Extract byte idx of a word.
  function automatic logic [7:0] get_byte(input logic [XLEN-1:0] word, input logic [1:0] idx);
    return word[{idx, 3'b000} +: 8];
  endfunction

  // Replace byte idx of a word.
  function automatic logic [XLEN-1:0] put_byte(input logic [XLEN-1:0] word, input logic [1:0] idx,
                                               input logic [7:0] b);
    logic [XLEN-1:0] w;
    w = word;
    w[{idx, 3'b000} +: 8] = b;
    return w;
  endfunction

  state_t                state_q, state_d;
  logic                  prio_q, prio_d;        // 1: D holds priority, 0: I holds it
  logic                  owner_q, owner_d;      // 1: D owns the access, 0: I owns it
  logic                  we_q, we_d;
  logic [1:0]            last_q, last_d;        // index of the final beat (N-1)
  logic [1:0]            cnt_q, cnt_d;          // current beat index
  logic [MEM_ADDR_W-1:0] base_q, base_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [XLEN-1:0]       asm_q, asm_d;          // read-byte assembly register
  logic [MEM_ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  i_rsp_valid_q, i_rsp_valid_d;
  logic [XLEN-1:0]       i_rsp_data_q, i_rsp_data_d;
  logic                  d_rsp_valid_q, d_rsp_valid_d;
  logic [XLEN-1:0]       d_rsp_data_q, d_rsp_data_d;

  logic                  grant_i_s, grant_d_s;
  logic [1:0]            req_last_s;
  logic [MEM_ADDR_W-1:0] req_base_s;
  logic                  req_we_s;
  logic [XLEN-1:0]       req_wdata_s;
  logic [1:0]            next_cnt_s;
  logic [XLEN-1:0]       final_s;
  logic                  unused_addr_s;

  // Upper address bits are deliberately ignored.
  assign unused_addr_s = ^{i_req_addr[XLEN-1:MEM_ADDR_W], d_req_addr[XLEN-1:MEM_ADDR_W]};

  // Round-robin arbitration and decode of the winning request.
  always_comb begin
    grant_d_s   = 1'b0;
    grant_i_s   = 1'b0;
    req_last_s  = 2'd3;
    req_base_s  = i_req_addr[MEM_ADDR_W-1:0];
    req_we_s    = 1'b0;
    req_wdata_s = {XLEN{1'b0}};
    if ((state_q == S_IDLE) && !rst) begin
      grant_d_s = d_req_valid && (!i_req_valid || prio_q);
      grant_i_s = i_req_valid && !grant_d_s;
    end else begin
      grant_d_s = 1'b0;
      grant_i_s = 1'b0;
    end
    if (grant_d_s) begin
      req_base_s  = d_req_addr[MEM_ADDR_W-1:0];
      req_we_s    = d_req_we;
      req_wdata_s = d_req_wdata;
      case (d_req_size)
        MASK_B:  req_last_s = 2'd0;
        MASK_H:  req_last_s = 2'd1;
        MASK_X:  req_last_s = 2'd3;
        default: req_last_s = 2'd3;
      endcase
    end else begin
      req_base_s  = i_req_addr[MEM_ADDR_W-1:0];
      req_we_s    = 1'b0;
      req_wdata_s = {XLEN{1'b0}};
      req_last_s  = 2'd3;
    end
  end

  // Next-state and registered-output computation for the beat sequencer.
  always_comb begin
    state_d       = state_q;
    prio_d        = prio_q;
    owner_d       = owner_q;
    we_d          = we_q;
    last_d        = last_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    wdata_d       = wdata_q;
    asm_d         = asm_q;
    mem_addr_d    = {MEM_ADDR_W{1'b0}};
    mem_re_d      = 1'b0;
    mem_we_d      = 1'b0;
    mem_wdata_d   = 8'd0;
    i_rsp_valid_d = 1'b0;
    i_rsp_data_d  = i_rsp_data_q;
    d_rsp_valid_d = 1'b0;
    d_rsp_data_d  = d_rsp_data_q;
    next_cnt_s    = cnt_q + 2'd1;
    final_s       = {XLEN{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (grant_d_s || grant_i_s) begin
          state_d     = S_BEAT;
          prio_d      = !grant_d_s;
          owner_d     = grant_d_s;
          we_d        = req_we_s;
          last_d      = req_last_s;
          cnt_d       = 2'd0;
          base_d      = req_base_s;
          wdata_d     = req_wdata_s;
          asm_d       = {XLEN{1'b0}};
          // Beat 0 strobes are registered here so they appear in the first beat cycle.
          mem_addr_d  = req_base_s;
          mem_we_d    = req_we_s;
          mem_re_d    = !req_we_s;
          mem_wdata_d = req_we_s ? req_wdata_s[7:0] : 8'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BEAT: begin
        // Read data of the previous beat arrives now.
        if ((cnt_q != 2'd0) && !we_q) begin
          asm_d = put_byte(asm_q, cnt_q - 2'd1, mem_rdata);
        end else begin
          asm_d = asm_q;
        end
        if (cnt_q == last_q) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d       = next_cnt_s;
          mem_addr_d  = base_q + {{(MEM_ADDR_W-2){1'b0}}, next_cnt_s};
          mem_we_d    = we_q;
          mem_re_d    = !we_q;
          mem_wdata_d = we_q ? get_byte(wdata_q, next_cnt_s) : 8'd0;
        end
      end
      S_DRAIN: begin
        if (we_q) begin
          final_s = {XLEN{1'b0}};
        end else begin
          final_s = put_byte(asm_q, last_q, mem_rdata);
        end
        asm_d   = final_s;
        state_d = S_RESP;
        if (owner_q) begin
          d_rsp_valid_d = 1'b1;
          d_rsp_data_d  = final_s;
        end else begin
          i_rsp_valid_d = 1'b1;
          i_rsp_data_d  = final_s;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset clears everything and gives D priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      prio_q        <= 1'b1;
      owner_q       <= 1'b0;
      we_q          <= 1'b0;
      last_q        <= 2'd0;
      cnt_q         <= 2'd0;
      base_q        <= {MEM_ADDR_W{1'b0}};
      wdata_q       <= {XLEN{1'b0}};
      asm_q         <= {XLEN{1'b0}};
      mem_addr_q    <= {MEM_ADDR_W{1'b0}};
      mem_re_q      <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_wdata_q   <= 8'd0;
      i_rsp_valid_q <= 1'b0;
      i_rsp_data_q  <= {XLEN{1'b0}};
      d_rsp_valid_q <= 1'b0;
      d_rsp_data_q  <= {XLEN{1'b0}};
    end else begin
      state_q       <= state_d;
      prio_q        <= prio_d;
      owner_q       <= owner_d;
      we_q          <= we_d;
      last_q        <= last_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      asm_q         <= asm_d;
      mem_addr_q    <= mem_addr_d;
      mem_re_q      <= mem_re_d;
      mem_we_q      <= mem_we_d;
      mem_wdata_q   <= mem_wdata_d;
      i_rsp_valid_q <= i_rsp_valid_d;
      i_rsp_data_q  <= i_rsp_data_d;
      d_rsp_valid_q <= d_rsp_valid_d;
      d_rsp_data_q  <= d_rsp_data_d;
    end
  end

  assign i_req_ready = grant_i_s;
  assign d_req_ready = grant_d_s;
  assign i_rsp_valid = i_rsp_valid_q;
  assign i_rsp_data  = i_rsp_data_q;
  assign d_rsp_valid = d_rsp_valid_q;
  assign d_rsp_data  = d_rsp_data_q;
  assign mem_addr    = mem_addr_q;
  assign mem_re      = mem_re_q;
  assign mem_we      = mem_we_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_riscv_mem_seq.sv
// Self-checking bench for riscv_mem_seq: directed scenarios plus random
// traffic, checked cycle by cycle against a transaction-level model.
module tb_riscv_mem_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req_valid, i_req_ready, i_rsp_valid;
  logic [31:0] i_req_addr, i_rsp_data;
  logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
  logic [31:0] d_req_addr, d_req_wdata, d_rsp_data;
  logic [1:0]  d_req_size;
  logic [6:0]  mem_addr;
  logic        mem_re, mem_we, busy;
  logic [7:0]  mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  riscv_mem_seq #(.XLEN(32), .MEM_ADDR_W(7)) dut (
    .clk(clk), .rst(rst),
    .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
    .i_rsp_valid(i_rsp_valid), .i_rsp_data(i_rsp_data),
    .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
    .d_req_we(d_req_we), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
    .d_rsp_valid(d_rsp_valid), .d_rsp_data(d_rsp_data),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Initial RAM content pattern.
  function automatic logic [7:0] pat(input int a);
    return 8'((a * 37 + 11) & 255);
  endfunction

  // Byte RAM with one-cycle registered read.
  logic [7:0] ram [128];
  logic       ram_init;
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 128; i++) ram[i] <= pat(i);
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr];
    end
  end

  // Reference model state.
  logic [7:0]  ref_mem [128];
  int          n_tests = 0, n_fail = 0, cyc = 0;
  bit          pend, p_owner_d, p_we, prio_d, acc_i, acc_d;
  int          p_n, p_base, p_acc;
  logic [31:0] p_wdata, p_data, exp_i_data, exp_d_data;
  int          grants[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend = 1'b0; prio_d = 1'b1; exp_i_data = 32'd0; exp_d_data = 32'd0;
  endtask

  // One clock cycle: check everything mid-cycle, then advance to just after the next edge.
  task automatic step();
    int  k;
    bit  idle, gi, gd, rsp_now;
    @(negedge clk);
    cyc++;
    acc_i = 1'b0; acc_d = 1'b0;
    chk("re_we_excl", 32'(mem_re & mem_we), 32'd0);
    chk("ready_excl", 32'(i_req_ready & d_req_ready), 32'd0);
    if (rst) begin
      chk("rst_strobes", {mem_addr, mem_re, mem_we, mem_wdata}, 32'd0);
      chk("rst_rsp_valid", {i_rsp_valid, d_rsp_valid, busy}, 32'd0);
      chk("rst_ready", {i_req_ready, d_req_ready}, 32'd0);
      chk("rst_i_data", i_rsp_data, 32'd0);
      chk("rst_d_data", d_rsp_data, 32'd0);
    end else begin
      k = cyc - p_acc - 1;
      if (pend && k >= 0 && k < p_n) begin
        chk("beat_addr", 32'(mem_addr), 32'((p_base + k) % 128));
        chk("beat_we", 32'(mem_we), 32'(p_we));
        chk("beat_re", 32'(mem_re), 32'(!p_we));
        chk("beat_wdata", 32'(mem_wdata), p_we ? 32'(p_wdata[8*k +: 8]) : 32'd0);
        if (p_we) ref_mem[(p_base + k) % 128] = p_wdata[8*k +: 8];
      end else begin
        chk("idle_strobes", {mem_addr, mem_re, mem_we, mem_wdata}, 32'd0);
      end
      rsp_now = pend && (cyc == p_acc + p_n + 2);
      if (rsp_now && p_owner_d) exp_d_data = p_data;
      if (rsp_now && !p_owner_d) exp_i_data = p_data;
      chk("i_rsp_valid", 32'(i_rsp_valid), 32'(rsp_now && !p_owner_d));
      chk("d_rsp_valid", 32'(d_rsp_valid), 32'(rsp_now && p_owner_d));
      chk("i_rsp_data", i_rsp_data, exp_i_data);
      chk("d_rsp_data", d_rsp_data, exp_d_data);
      idle = !(pend && cyc > p_acc && cyc <= p_acc + p_n + 2);
      chk("busy", 32'(busy), 32'(!idle));
      if (rsp_now) pend = 1'b0;
      gd = idle && d_req_valid && (!i_req_valid || prio_d);
      gi = idle && i_req_valid && !gd;
      chk("i_req_ready", 32'(i_req_ready), 32'(gi));
      chk("d_req_ready", 32'(d_req_ready), 32'(gd));
      if (gd || gi) begin
        pend = 1'b1; p_acc = cyc; p_owner_d = gd; prio_d = !gd;
        acc_i = gi; acc_d = gd;
        grants.push_back(gd ? 1 : 0);
        p_we    = gd && d_req_we;
        p_base  = gd ? int'(d_req_addr[6:0]) : int'(i_req_addr[6:0]);
        p_wdata = gd ? d_req_wdata : 32'd0;
        p_n     = gi ? 4 : (d_req_size == 2'd0) ? 1 : (d_req_size == 2'd1) ? 2 : 4;
        p_data  = 32'd0;
        if (!p_we)
          for (int j = 0; j < p_n; j++) p_data |= 32'(ref_mem[(p_base + j) % 128]) << (8 * j);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic req_d(input logic [31:0] a, input logic we, input logic [1:0] sz, input logic [31:0] wd);
    int t;
    d_req_addr = a; d_req_we = we; d_req_size = sz; d_req_wdata = wd; d_req_valid = 1'b1;
    t = 0;
    do begin step(); t++; end while (!acc_d && t < 30);
    chk("d_accept", 32'(acc_d), 32'd1);
    d_req_valid = 1'b0;
  endtask

  task automatic req_i(input logic [31:0] a);
    int t;
    i_req_addr = a; i_req_valid = 1'b1;
    t = 0;
    do begin step(); t++; end while (!acc_i && t < 30);
    chk("i_accept", 32'(acc_i), 32'd1);
    i_req_valid = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1; model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ram_init = 1'b1;
    i_req_valid = 1'b0; i_req_addr = 32'd0;
    d_req_valid = 1'b0; d_req_addr = 32'd0; d_req_we = 1'b0; d_req_size = 2'd0; d_req_wdata = 32'd0;
    for (int i = 0; i < 128; i++) ref_mem[i] = pat(i);
    model_reset();
    idle_cycles(3);
    rst = 1'b0; ram_init = 1'b0;
    idle_cycles(2);

    // Fetch of a word placed by a store.
    req_d(32'h10, 1'b1, 2'd2, 32'h00100193);
    idle_cycles(6);
    req_i(32'hFFFF_FF10);
    idle_cycles(6);
    chk("fetch_word", i_rsp_data, 32'h00100193);

    // Half store.
    req_d(32'h20, 1'b1, 2'd1, 32'hDEADBEEF);
    idle_cycles(4);
    chk("sh_ram20", 32'(ram[32'h20]), 32'hEF);
    chk("sh_ram21", 32'(ram[32'h21]), 32'hBE);
    chk("sh_ram22", 32'(ram[32'h22]), 32'(pat(32'h22)));
    chk("sh_rsp", d_rsp_data, 32'd0);

    // Byte load, zero-extended.
    req_d(32'h5, 1'b1, 2'd0, 32'h0000_0080);
    idle_cycles(3);
    req_d(32'h5, 1'b0, 2'd0, 32'd0);
    idle_cycles(3);
    chk("lb_data", d_rsp_data, 32'h00000080);

    // Wrapping word load.
    req_d(32'h7E, 1'b0, 2'd3, 32'd0);
    idle_cycles(6);
    chk("wrap_data", d_rsp_data, {pat(1), pat(0), pat(127), pat(126)});

    // Reset in the third beat of a word store.
    req_d(32'h40, 1'b1, 2'd2, 32'h11223344);
    idle_cycles(2);
    pulse_reset();
    idle_cycles(3);
    chk("rst_ram40", 32'(ram[32'h40]), 32'h44);
    chk("rst_ram41", 32'(ram[32'h41]), 32'h33);
    chk("rst_ram42", 32'(ram[32'h42]), 32'(pat(32'h42)));
    chk("rst_ram43", 32'(ram[32'h43]), 32'(pat(32'h43)));
    req_d(32'h40, 1'b0, 2'd2, 32'd0);
    idle_cycles(6);
    chk("after_rst_load", d_rsp_data, {pat(32'h43), pat(32'h42), 8'h33, 8'h44});

    // Contention from reset: grants alternate starting with D.
    pulse_reset();
    grants.delete();
    i_req_addr = $urandom; i_req_valid = 1'b1;
    d_req_addr = $urandom; d_req_we = 1'b0; d_req_size = 2'd2; d_req_valid = 1'b1;
    for (int t = 0; t < 60 && grants.size() < 4; t++) begin
      step();
      if (acc_i) i_req_addr = $urandom;
      if (acc_d) d_req_addr = $urandom;
    end
    chk("cont_ngrants", 32'(grants.size()), 32'd4);
    for (int g = 0; g < 4 && g < grants.size(); g++)
      chk("cont_order", 32'(grants[g]), (g % 2 == 0) ? 32'd1 : 32'd0);
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    idle_cycles(8);

    // Random traffic.
    for (int t = 0; t < 3000; t++) begin
      step();
      if (acc_i || !i_req_valid) begin
        i_req_valid = ($urandom_range(0, 2) == 0);
        i_req_addr  = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        i_req_valid = 1'b0;
      end
      if (acc_d || !d_req_valid) begin
        d_req_valid = ($urandom_range(0, 2) == 0);
        d_req_addr  = $urandom;
        d_req_we    = $urandom_range(0, 1) == 1;
        d_req_size  = 2'($urandom_range(0, 3));
        d_req_wdata = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        d_req_valid = 1'b0;
      end
      if ($urandom_range(0, 299) == 0) pulse_reset();
    end
    i_req_valid = 1'b0; d_req_valid = 1'b0;
    idle_cycles(10);
    for (int a = 0; a < 128; a++) chk("ram_final", 32'(ram[a]), 32'(ref_mem[a]));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
